// File: rtl/adaptimer_pkg.sv
// Shared definitions for the adaptive-timer readout block: register map,
// AXI response codes and STATUS field positions.
package adaptimer_pkg;

    // Register selector = byte offset >> 2 (ARADDR[4:2]).
    typedef enum logic [2:0] {
        REG_TIME_LO = 3'd0,
        REG_TIME_HI = 3'd1,
        REG_CAP_LO  = 3'd2,
        REG_CAP_HI  = 3'd3,
        REG_STATUS  = 3'd4
    } reg_sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STAT_COUNT_W   = 5;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 31;

endpackage

// File: rtl/adaptimer_readout_fifo.sv
// Timestamp capture FIFO: 64-bit entries, power-of-two depth, combinational head,
// simultaneous push/pop allowed when full.
module timestamp_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      i_push,
    input  logic [63:0]               i_data,
    input  logic                      i_pop,
    output logic [63:0]               o_head,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_drop    = i_push & ~w_push_ok;

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adaptimer_readout.sv
// AXI4-Lite read-only view of the adaptive timer: coherent LO/HI timer reads
// through a shadow register, plus a FIFO of event-captured timestamps.
module adaptimer_readout #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [63:0]           adaptimer,
    input  logic                  capture_trig,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);
    import adaptimer_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          r_trig_d;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;
    logic [31:0]   r_shadow_hi;
    logic          r_overflow;

    logic          w_ar_hs;
    reg_sel_e      w_sel;
    logic          w_rise;
    logic          w_pop;
    logic          w_status_rd;
    logic [63:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_drop;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic [1:0]    w_rresp;
    logic          w_unused_addr;

    assign S_AXI_ARREADY = ~r_rvalid;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    assign w_ar_hs       = S_AXI_ARVALID & ~r_rvalid;
    assign w_sel         = reg_sel_e'(S_AXI_ARADDR[4:2]);
    assign w_rise        = capture_trig & ~r_trig_d;
    assign w_pop         = w_ar_hs & (w_sel == REG_CAP_HI);
    assign w_status_rd   = w_ar_hs & (w_sel == REG_STATUS);
    // Only ARADDR[4:2] participates in decode.
    assign w_unused_addr = ^S_AXI_ARADDR;

    timestamp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_rise),
        .i_data  (adaptimer),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_status                       = '0;
        w_status[STAT_COUNT_W-1:0]     = STAT_COUNT_W'(w_count);
        w_status[STAT_EMPTY_BIT]       = w_empty;
        w_status[STAT_FULL_BIT]        = w_full;
        w_status[STAT_OVF_BIT]         = r_overflow;
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = RESP_OKAY;
        case (w_sel)
            REG_TIME_LO: w_rdata = adaptimer[31:0];
            REG_TIME_HI: w_rdata = r_shadow_hi;
            REG_CAP_LO:  w_rdata = w_empty ? 32'd0 : w_head[31:0];
            REG_CAP_HI:  w_rdata = w_empty ? 32'd0 : w_head[63:32];
            REG_STATUS:  w_rdata = w_status;
            default:     w_rresp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_trig_d    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
            r_shadow_hi <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_trig_d   <= capture_trig;
            // A drop in the same cycle as a STATUS read wins over the clear.
            r_overflow <= w_drop | (r_overflow & ~w_status_rd);
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
                if (w_sel == REG_TIME_LO) begin
                    r_shadow_hi <= adaptimer[63:32];
                end
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adaptimer_readout.sv
// Directed bench for adaptimer_readout: vector table for the register map,
// hand-written sequences for stalls, overflow, coincident pop/push and reset.
module tb_adaptimer_readout;

    logic        clock;
    logic        resetn;
    logic [63:0] adaptimer;
    logic        capture_trig;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_cmp = 0;
    int n_bad = 0;

    adaptimer_readout #(
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (5)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .adaptimer     (adaptimer),
        .capture_trig  (capture_trig),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] timer;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One read beat: AR handshake on the next edge (optionally with a capture
    // edge in the same cycle), data sampled one cycle later, RREADY held high.
    task automatic axi_read(input logic [4:0] a, input logic [63:0] t, input logic trig,
                            output logic [31:0] d, output logic [1:0] r);
        @(negedge clock);
        adaptimer    = t;
        araddr       = a;
        arvalid      = 1'b1;
        rready       = 1'b1;
        capture_trig = trig;
        @(negedge clock);
        arvalid      = 1'b0;
        capture_trig = 1'b0;
        adaptimer    = ~t;
        check($sformatf("rvalid_up@%h", a), {31'd0, rvalid}, 32'd1);
        d = rdata;
        r = rresp;
        @(negedge clock);
        check($sformatf("rvalid_down@%h", a), {31'd0, rvalid}, 32'd0);
        $display("read addr=%h data=%h resp=%b", a, d, r);
    endtask

    task automatic read_expect(input string nm, input logic [4:0] a, input logic [63:0] t,
                               input logic trig, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, t, trig, d, r);
        check(nm, d, exp);
    endtask

    task automatic pulse(input logic [63:0] t);
        @(negedge clock);
        adaptimer    = t;
        capture_trig = 1'b1;
        @(negedge clock);
        capture_trig = 1'b0;
        $display("capture timer=%h", t);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        resetn = 1'b1; adaptimer = '0; capture_trig = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        #2 resetn = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_rresp",   {30'd0, rresp},   32'd0);
        resetn = 1'b1;

        pulse(64'd100);
        pulse(64'd200);

        vecs[0]  = '{5'h00, 64'h0000_0012_8000_0040, 32'h8000_0040, 2'b00};
        vecs[1]  = '{5'h04, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0012, 2'b00};
        vecs[2]  = '{5'h08, 64'h0,                   32'd100,       2'b00};
        vecs[3]  = '{5'h0C, 64'h0,                   32'd0,         2'b00};
        vecs[4]  = '{5'h08, 64'h0,                   32'd200,       2'b00};
        vecs[5]  = '{5'h0C, 64'h0,                   32'd0,         2'b00};
        vecs[6]  = '{5'h10, 64'h0,                   32'h0000_0100, 2'b00};
        vecs[7]  = '{5'h08, 64'h0,                   32'd0,         2'b00};
        vecs[8]  = '{5'h14, 64'h0,                   32'd0,         2'b10};
        vecs[9]  = '{5'h18, 64'h0,                   32'd0,         2'b10};
        vecs[10] = '{5'h1C, 64'h0,                   32'd0,         2'b10};
        vecs[11] = '{5'h04, 64'h1111_2222_3333_4444, 32'h0000_0012, 2'b00};
        vecs[12] = '{5'h00, 64'hDEAD_BEEF_0123_4567, 32'h0123_4567, 2'b00};
        vecs[13] = '{5'h04, 64'h0,                   32'hDEAD_BEEF, 2'b00};

        for (int i = 0; i < 14; i++) begin
            axi_read(vecs[i].addr, vecs[i].timer, 1'b0, d, r);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_resp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
        end

        // Stalled read: RREADY low for 5 cycles
        @(negedge clock);
        adaptimer = 64'h0000_0055_1234_5678; araddr = 5'h00; arvalid = 1'b1; rready = 1'b0;
        @(negedge clock);
        arvalid = 1'b0; adaptimer = '0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_rvalid", i),  {31'd0, rvalid},  32'd1);
            check($sformatf("stall%0d_rdata", i),   rdata,            32'h1234_5678);
            check($sformatf("stall%0d_arready", i), {31'd0, arready}, 32'd0);
            @(negedge clock);
        end
        rready = 1'b1;
        @(negedge clock);
        check("stall_end_rvalid",  {31'd0, rvalid},  32'd0);
        check("stall_end_arready", {31'd0, arready}, 32'd1);
        $display("stall beat done");

        // Overflow: five edges into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) pulse({32'h0000_00A0, 32'h1000 + i});
        read_expect("ovf_status1", 5'h10, 64'h0, 1'b0, 32'h8000_0204);
        read_expect("ovf_status2", 5'h10, 64'h0, 1'b0, 32'h0000_0204);

        // Full: CAP_HI pop coincident with a capture edge
        read_expect("coinc_pop_hi", 5'h0C, 64'h0000_00A0_0000_2000, 1'b1, 32'h0000_00A0);
        read_expect("coinc_status", 5'h10, 64'h0, 1'b0, 32'h0000_0204);

        // Full: STATUS read coincident with a dropped push keeps overflow set
        read_expect("stclr_status", 5'h10, 64'h0000_00A0_0000_3000, 1'b1, 32'h0000_0204);
        read_expect("stclr_after1", 5'h10, 64'h0, 1'b0, 32'h8000_0204);
        read_expect("stclr_after2", 5'h10, 64'h0, 1'b0, 32'h0000_0204);

        // Drain: order and tail value
        read_expect("drain_lo0", 5'h08, 64'h0, 1'b0, 32'h1002);
        read_expect("drain_hi0", 5'h0C, 64'h0, 1'b0, 32'hA0);
        read_expect("drain_lo1", 5'h08, 64'h0, 1'b0, 32'h1003);
        read_expect("drain_hi1", 5'h0C, 64'h0, 1'b0, 32'hA0);
        read_expect("drain_lo2", 5'h08, 64'h0, 1'b0, 32'h1004);
        read_expect("drain_hi2", 5'h0C, 64'h0, 1'b0, 32'hA0);
        read_expect("drain_lo3", 5'h08, 64'h0, 1'b0, 32'h2000);
        read_expect("drain_hi3", 5'h0C, 64'h0, 1'b0, 32'hA0);
        read_expect("drain_status", 5'h10, 64'h0, 1'b0, 32'h0000_0100);

        // Reset mid-transaction, trigger held high across release
        pulse(64'd11);
        pulse(64'd22);
        @(negedge clock);
        adaptimer = 64'h0; araddr = 5'h00; arvalid = 1'b1; rready = 1'b0;
        @(negedge clock);
        arvalid = 1'b0;
        check("midrst_rvalid_before", {31'd0, rvalid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_rvalid",  {31'd0, rvalid},  32'd0);
        check("midrst_arready", {31'd0, arready}, 32'd1);
        check("midrst_rdata",   rdata,            32'd0);
        @(negedge clock);
        adaptimer = 64'h0000_0007_0000_0077; capture_trig = 1'b1;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        capture_trig = 1'b0;
        $display("reset released with trigger high");
        read_expect("postrst_status", 5'h10, 64'h0, 1'b0, 32'h0000_0001);
        read_expect("postrst_cap_lo", 5'h08, 64'h0, 1'b0, 32'h0000_0077);
        read_expect("postrst_cap_hi", 5'h0C, 64'h0, 1'b0, 32'h0000_0007);
        read_expect("postrst_empty",  5'h10, 64'h0, 1'b0, 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adaptimer_readout.md
ADAPTIMER_READOUT -- requirements
Module: adaptimer_readout

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 64-bit capture entries; SHALL be a power of two, 2..16.
REQ-002 Parameter ADDR_WIDTH, default 5, width of S_AXI_ARADDR.
REQ-003 clock  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 adaptimer  in  64  timestamp from the adaptive-resolution timer, synchronous to clock.
REQ-006 capture_trig  in  1  event strobe, synchronous to clock; a rising edge requests a capture.
REQ-007 S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
REQ-008 S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  AXI4-Lite read-address handshake.
REQ-009 S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  AXI4-Lite read-data channel.

Function
REQ-010 Address map, on ARADDR[4:2]: 0x00 TIME_LO, 0x04 TIME_HI, 0x08 CAP_LO, 0x0C CAP_HI, 0x10 STATUS; any other address SHALL return RDATA 0 with RRESP SLVERR (2'b10).
REQ-011 ARREADY SHALL be 1 exactly when RVALID is 0, so at most one read is outstanding.
REQ-012 An AR handshake in cycle N SHALL raise RVALID in cycle N+1 with RDATA/RRESP valid; RDATA/RRESP/RVALID SHALL hold until RVALID&&RREADY, and RVALID SHALL drop the cycle after.
REQ-013 TIME_LO: RDATA = adaptimer[31:0] sampled in the AR handshake cycle; in the same cycle shadow_hi <= adaptimer[63:32].
REQ-014 TIME_HI: RDATA = shadow_hi, so a LO-then-HI read pair is coherent; shadow_hi SHALL remain unchanged by any other access.
REQ-015 Capture: rise = capture_trig & ~trig_d (trig_d registered, reset 0); on rise, adaptimer is pushed to the FIFO in that cycle.
REQ-016 CAP_LO SHALL return head[31:0] without popping; CAP_HI SHALL return head[63:32] and pop the head in the AR handshake cycle.
REQ-017 Read of CAP_LO/CAP_HI when empty SHALL return 0, RRESP OKAY, no pop.
REQ-018 Push when full with no same-cycle pop SHALL be dropped and set sticky overflow; push and pop in the same cycle when full SHALL both succeed, count unchanged.
REQ-019 STATUS: RDATA[4:0] = entry count (0..FIFO_DEPTH), [8] empty, [9] full, [31] overflow, others 0; all values from the handshake cycle.
REQ-020 A STATUS read SHALL clear overflow; if an overflow event occurs in the same cycle, overflow SHALL remain 1.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-022 RRESP SHALL be OKAY (2'b00) for every mapped address.

Reset
REQ-023 While resetn=0: ARREADY 1, RVALID 0, RDATA 0, RRESP 0, shadow_hi 0, trig_d 0, FIFO empty (pointers 0, count 0), overflow 0.
REQ-024 Reset asserted mid-transaction SHALL abort it; after release no stale RVALID and no captured entry SHALL remain.
REQ-025 A capture_trig already high at reset release SHALL count as a rising edge on the first clock after release.

Structure
REQ-026 Shared package adaptimer_pkg SHALL hold the register offsets, the RRESP codes (OKAY, SLVERR) and the STATUS bit positions.
REQ-027 The FIFO SHALL be one sub-module, timestamp_fifo (64-bit data, parameter DEPTH, push/pop/full/empty/count/head outputs); the AXI decode and shadow logic SHALL stay at top level.

Verification
REQ-028 Read 0x00 with adaptimer=64'h0000_0012_8000_0040, then let it change, then read 0x04 -> RDATA 32'h8000_0040, then 32'h0000_0012.
REQ-029 Hold RREADY=0 for 5 cycles after the 0x00 handshake -> RVALID and RDATA stable, ARREADY 0 throughout; single RVALID&&RREADY ends the beat.
REQ-030 Pulse capture_trig at adaptimer=100, 200 (DEPTH=4), then read 0x08, 0x0C, 0x08, 0x0C -> 100, 0, 200, 0; STATUS count 0, empty 1.
REQ-031 Five rising edges with no pops (DEPTH=4) -> STATUS = 32'h8000_0204 (count 4, full, overflow); next STATUS read -> 32'h0000_0204.
REQ-032 Full FIFO, CAP_HI handshake coincident with a capture rise -> count stays 4, new value at tail, overflow stays 0.
REQ-033 Read 0x14 -> RDATA 0, RRESP 2'b10; read 0x08 on an empty FIFO -> RDATA 0, RRESP 2'b00.
